// File: rtl/pipe_pkg.sv
// Shared types and constants for the two-entry skid pipeline stage.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int SKID_DEPTH = 2;
  localparam int OCC_W      = 2;

endpackage

// File: rtl/pipe_data_reg.sv
// Write-enabled payload register with asynchronous active-high reset to zero.
module pipe_data_reg #(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wen,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (wen) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_stage.sv
// Two-entry valid/ready skid stage: in_ready comes only from registered state,
// so backpressure never propagates combinationally from out_ready.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_data,
  output logic [OCC_W-1:0] occupancy
);

  // Handshake: a beat moves on a rising clk edge when valid and ready are
  // both high; a producer must hold valid and data stable until it moves.
  skid_state_t      state;
  logic             in_fire;
  logic             out_fire;
  logic             main_wen;
  logic             skid_wen;
  logic [width-1:0] main_d;
  logic [width-1:0] main_q;
  logic [width-1:0] skid_q;

  assign in_ready  = !reset && (state != FULL);
  assign out_valid = (state != EMPTY) && !flush;
  assign out_data  = main_q;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    occupancy = '0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      BUSY:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Main takes the skid beat when draining FULL, otherwise the producer beat.
  always_comb begin
    main_wen = 1'b0;
    skid_wen = 1'b0;
    main_d   = in_data;
    if (!flush) begin
      case (state)
        EMPTY: main_wen = in_fire;
        BUSY: begin
          main_wen = in_fire && out_fire;
          skid_wen = in_fire && !out_fire;
        end
        FULL: begin
          main_wen = out_fire;
          main_d   = skid_q;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_fire) state <= BUSY;
        BUSY: begin
          if (in_fire && !out_fire) state <= FULL;
          else if (!in_fire && out_fire) state <= EMPTY;
        end
        FULL: if (out_fire) state <= BUSY;
        default: state <= EMPTY;
      endcase
    end
  end

  pipe_data_reg #(.width(width)) u_main (
    .clk   (clk),
    .reset (reset),
    .wen   (main_wen),
    .d     (main_d),
    .q     (main_q)
  );

  pipe_data_reg #(.width(width)) u_skid (
    .clk   (clk),
    .reset (reset),
    .wen   (skid_wen),
    .d     (in_data),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and scoreboard-checked stimulus for pipe_skid_stage.
module tb_pipe_skid_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic [1:0]  occupancy;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  pipe_skid_stage #(.width(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  initial begin
    // Reset state with stimulus already waiting
    in_valid  = 1'b1;
    in_data   = 32'hA5A5A5A5;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_occ", {30'b0, occupancy}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    #1;
    check("rel_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("first_valid", {31'b0, out_valid}, 32'd1);
    check("first_data", out_data, 32'hA5A5A5A5);
    check("first_occ", {30'b0, occupancy}, 32'd1);
    in_valid = 1'b0;
    tick();
    check("first_drain_occ", {30'b0, occupancy}, 32'd0);

    // Streaming without bubbles
    push(32'd1);
    for (int i = 1; i <= 16; i++) begin
      check("stream_valid", {31'b0, out_valid}, 32'd1);
      check("stream_data", out_data, i);
      check("stream_occ", {30'b0, occupancy}, 32'd1);
      in_data = i + 1;
      if (i == 16) in_valid = 1'b0;
      tick();
    end
    check("stream_end_occ", {30'b0, occupancy}, 32'd0);

    // Fill under backpressure
    out_ready = 1'b0;
    push(32'h11);
    push(32'h22);
    in_data = 32'h33;
    check("full_occ", {30'b0, occupancy}, 32'd2);
    check("full_in_ready", {31'b0, in_ready}, 32'd0);
    check("full_main", out_data, 32'h11);
    tick();
    check("full_hold_occ", {30'b0, occupancy}, 32'd2);
    out_ready = 1'b1;
    #1;
    check("drain0", out_data, 32'h11);
    tick();
    check("drain1", out_data, 32'h22);
    check("drain1_in_ready", {31'b0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("drain2", out_data, 32'h33);
    check("drain2_occ", {30'b0, occupancy}, 32'd1);
    tick();
    check("drain_end_occ", {30'b0, occupancy}, 32'd0);

    // Flush while FULL
    out_ready = 1'b0;
    push(32'h44);
    push(32'h55);
    in_valid = 1'b0;
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_gate", {31'b0, out_valid}, 32'd0);
    tick();
    flush = 1'b0;
    #1;
    check("flush_occ", {30'b0, occupancy}, 32'd0);
    check("flush_in_ready", {31'b0, in_ready}, 32'd1);
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    tick();
    check("flush_valid2", {31'b0, out_valid}, 32'd0);

    // Asynchronous reset while FULL
    out_ready = 1'b0;
    push(32'h66);
    push(32'h67);
    in_valid = 1'b0;
    check("pre_arst_occ", {30'b0, occupancy}, 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check("arst_valid", {31'b0, out_valid}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd0);
    check("arst_occ", {30'b0, occupancy}, 32'd0);
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    push(32'h77);
    in_valid = 1'b0;
    check("post_arst_valid", {31'b0, out_valid}, 32'd1);
    check("post_arst_data", out_data, 32'h77);
    tick();
    check("post_arst_occ", {30'b0, occupancy}, 32'd0);

    // Random traffic against a queue model
    exp_q.delete();
    for (int c = 0; c < 10000; c++) begin
      logic iv, ordy, fl, exp_ir, saved_ir;
      logic [31:0] d;
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      fl   = ($urandom_range(0, 49) == 0);
      d    = $urandom;
      in_valid = iv;
      in_data = d;
      out_ready = ordy;
      flush = fl;
      #1;
      exp_ir = (exp_q.size() < 2);
      check("rnd_in_ready", {31'b0, in_ready}, {31'b0, exp_ir});
      check("rnd_occ", {30'b0, occupancy}, exp_q.size());
      check("rnd_valid", {31'b0, out_valid}, {31'b0, (exp_q.size() > 0) && !fl});
      if (exp_q.size() > 0 && !fl) check("rnd_data", out_data, exp_q[0]);
      saved_ir = in_ready;
      out_ready = !ordy;
      #1;
      check("rnd_ready_comb", {31'b0, in_ready}, {31'b0, saved_ir});
      out_ready = ordy;
      #1;
      if (fl) begin
        exp_q.delete();
      end else begin
        if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
        if (iv && exp_ir) exp_q.push_back(d);
      end
      tick();
    end
    flush = 1'b0;
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Two-entry valid/ready pipeline stage inserted between producer logic and a consuming holding register.
- Fully registers the backpressure path: in_ready depends only on internal state, so there is no combinational path from out_ready to in_ready.
- Sustains one transfer per cycle with no bubbles.
- Provides a synchronous flush for pipeline redirect/kill.

Parameters:
- width, 32, payload width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of all held and in-flight beats.
- in_valid  input  1  producer has a beat.
- in_ready  output  1  stage can accept a beat.
- in_data  input  width  producer payload.
- out_valid  output  1  stage presents a beat.
- out_ready  input  1  consumer accepts a beat.
- out_data  output  width  payload presented to the consumer.
- occupancy  output  2  number of beats held (0..2).

Behaviour:
- Reset and clocking:
  - Clock is clk. Reset is asynchronous and active-high, named reset; all state uses it.
  - While reset is asserted: state=EMPTY, main and skid data regs=0, out_valid=0, occupancy=0, in_ready=0 (gated by reset).
  - The first accept is possible in the first cycle after reset deasserts.
- Transfer definitions:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Output and ready equations:
  - in_ready = !reset & (state != FULL). Registered state only.
  - out_valid = (state != EMPTY) & !flush.
  - out_data = main reg, always. Value is don't-care when out_valid=0, but it must not be X after reset.
  - occupancy: EMPTY=0, BUSY=1, FULL=2.
- State machine (stateful transitions apply only when flush=0):
  - EMPTY:
    - in_fire: main<=in_data, go to BUSY.
    - otherwise: stay in EMPTY.
  - BUSY:
    - in_fire & out_fire: main<=in_data, stay in BUSY.
    - in_fire only: skid<=in_data, go to FULL.
    - out_fire only: go to EMPTY.
    - neither: hold.
  - FULL (in_ready=0):
    - out_fire: main<=skid, go to BUSY.
    - otherwise: hold both regs.
- Latency:
  - A beat accepted into an empty stage appears on out_data/out_valid the next cycle.
  - Order is strictly FIFO: main is always older than skid.
- Flush:
  - Highest priority over all transitions.
  - Next state is EMPTY.
  - Any beat accepted by in_fire in the flush cycle is discarded.
  - No output transfer occurs in the flush cycle, because out_valid is gated.
  - Data regs may keep stale values.
- Boundary conditions:
  - FULL with in_valid=1: beat is not accepted; the producer must hold it.
  - out_ready=1 while EMPTY: no effect.
  - Simultaneous in_fire/out_fire in BUSY: occupancy stays 1 and the payload is replaced.
  - Reset asserted mid-operation: held beats are lost immediately (asynchronous).
  - flush and reset together: reset wins.
- Protocol assertions (for the verification engineer):
  - Once out_valid rises, it stays high with out_data stable until out_fire or flush.
  - occupancy never exceeds 2.

Decomposition:
- Shared package pipe_pkg:
  - typedef enum logic [1:0] skid_state_t {EMPTY=2'd0, BUSY=2'd1, FULL=2'd2}.
  - Constants SKID_DEPTH=2, OCC_W=2.
- One natural sub-module: pipe_data_reg.
  - Parameterised width.
  - Ports: clk, asynchronous active-high reset, wen, d, q. Reset value 0.
  - Instantiated twice (main, skid). The FSM and control stay in pipe_skid_stage.

Test Plan:
- Reset release, in_valid=1, in_data=0xA5A5A5A5, out_ready=1 -> after reset: in_ready=1; out_valid=1 with out_data=0xA5A5A5A5 the next cycle; occupancy returns to 0 after the transfer.
- Streaming 0x1..0x10 with in_valid and out_ready held high -> 16 outputs on 16 consecutive cycles, in order, with no bubbles; occupancy stays 1.
- Push 0x11, 0x22, 0x33 with out_ready=0 -> 0x11 in main, 0x22 in skid, occupancy=2, in_ready=0, 0x33 held by the producer. Then raise out_ready -> outputs 0x11, 0x22, 0x33 on consecutive cycles.
- FULL (0x44, 0x55) plus a flush pulse with out_ready=1 -> out_valid=0 in the flush cycle; next cycle occupancy=0, in_ready=1; 0x44 and 0x55 are never output.
- Assert reset asynchronously (between clock edges) while FULL -> out_valid, in_ready and occupancy drop to 0 immediately, without waiting for a clock edge. After release, a new beat 0x77 passes through normally.
- Random valid/ready for 10k cycles against a scoreboard FIFO -> zero order or data mismatches, and in_ready never changes combinationally with out_ready.
